exe_muldiv: RTL and testbench
=============================

EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and HI/LO width (even, >=4).
REQ-002 SHALL have parameter MUL_CYCLES, default 2, meaning the number of MUL-state cycles (>=1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, an operation request, sampled only in IDLE.
REQ-006 SHALL have port op, input, 2, with encoding 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have ports src1 and src2, input, WIDTH, the operands (dividend and divisor for DIV/DIVU).
REQ-008 SHALL have port cancel, input, 1, a pipeline flush that aborts an in-flight operation.
REQ-009 SHALL have ports hi_we and lo_we, input, 1, direct MTHI/MTLO write enables.
REQ-010 SHALL have port wdata, input, WIDTH, the direct-write data.
REQ-011 SHALL have ports hi and lo, output, WIDTH, the registered HI/LO values.
REQ-012 SHALL have port busy, output, 1, asserted when state is not IDLE.
REQ-013 SHALL have port done, output, 1, a one-cycle result-commit pulse.
REQ-014 SHALL have port arith_stall, output, 1, the pipeline stall request.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV, FIX, DONE.
REQ-016 SHALL leave IDLE when start=1 and cancel=0: to MUL for op[1]=0, to DIV for op[1]=1; operands and op are latched on that edge.
REQ-017 SHALL hold MUL for exactly MUL_CYCLES cycles, then go to DONE; start cycle T -> done at T+MUL_CYCLES+1 (T+3 at default).
REQ-018 SHALL compute MULT as the signed 2*WIDTH product and MULTU as the unsigned 2*WIDTH product; internal pipelining of the product is free.
REQ-019 SHALL perform DIV/DIVU as radix-2 restoring division on operand magnitudes, one quotient bit per cycle, for exactly WIDTH cycles in DIV.
REQ-020 SHALL spend one FIX cycle after DIV applying sign correction (quotient negated if operand signs differ; remainder takes the dividend's sign; signed only), then go to DONE; div done at T+WIDTH+2 (T+34 at default).
REQ-021 SHALL produce quotient all-ones and remainder=src1 for a zero divisor, for both signed and unsigned, with no exception.
REQ-022 SHALL produce quotient=src1 and remainder 0 for signed most-negative / -1, with no exception.
REQ-023 SHALL, in DONE, assert done for one cycle, write the result (mult: hi=product[2W-1:W], lo=product[W-1:0]; div: hi=remainder, lo=quotient) on the exiting edge, and return to IDLE.
REQ-024 SHALL have arith_stall = (state==IDLE & start & ~cancel) | state in {MUL, DIV, FIX}; it SHALL be 0 in DONE.
REQ-025 SHALL ignore start when state is not IDLE.
REQ-026 SHALL, when cancel=1 in MUL/DIV/FIX/DONE, go to IDLE next edge with no done and hi/lo unchanged.
REQ-027 SHALL ignore start when cancel=1 in IDLE.
REQ-028 SHALL apply hi_we/lo_we writes of wdata on the next edge in IDLE or DONE and ignore them in MUL/DIV/FIX.
REQ-029 SHALL, when a hi_we/lo_we write coincides with the DONE commit, let the direct write win for that register only.
REQ-030 SHALL let a new start be accepted in the first IDLE cycle after DONE or after cancel.

Reset
REQ-031 SHALL, on rst, asynchronously force state=IDLE, hi=0, lo=0, done=0, busy=0, arith_stall=0 and clear the latched operands and counters.
REQ-032 SHALL, on rst mid-operation, lose the operation with no done after release; the first cycle after release is IDLE.

Verification
REQ-033 SHALL verify MULT: src1=0xFFFFFFFD, src2=5 at T -> done at T+3, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-034 SHALL verify MULTU: 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; arith_stall high T..T+2, low at T+3.
REQ-035 SHALL verify DIV: 0xFFFFFFF9 / 2 -> done at T+34, lo=0xFFFFFFFD, hi=0xFFFFFFFF; also 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 SHALL verify DIVU: 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-037 SHALL verify cancel: DIV started at T, cancel at T+10 -> no done, hi/lo retain prior values, new MULT start at T+11 accepted.
REQ-038 SHALL verify collision and reset: lo_we=1 with wdata=0x12345678 in the DONE cycle of a MULT -> lo=0x12345678 and hi=product high; rst pulse at T+5 of a DIV -> hi=lo=0, state IDLE, no done.

Source files
------------

// File: rtl/exe_muldiv.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Multiplies take MUL_CYCLES cycles. Divides use radix-2 restoring division plus one sign-fix cycle.
module exe_muldiv #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             arith_stall
);

    // state  | meaning
    // S_IDLE | waiting for start; direct HI/LO writes allowed
    // S_MUL  | product settling, cnt counts down MUL_CYCLES
    // S_DIV  | one restoring-division quotient bit per cycle
    // S_FIX  | sign correction and zero-divisor override
    // S_DONE | commit result to HI/LO, pulse done
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, quo, rem;
    logic [CW-1:0]      cnt;

    logic               is_signed, a_neg, b_neg, div_zero, src1_neg, ge;
    logic [WIDTH-1:0]   b_mag, rem_nxt, rem_sub, res_hi, res_lo;
    logic [WIDTH:0]     rem_sh;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;

    always_comb begin
        is_signed = ~op_q[0];
        a_neg     = is_signed & a_q[WIDTH-1];
        b_neg     = is_signed & b_q[WIDTH-1];
        b_mag     = b_neg ? -b_q : b_q;
        div_zero  = (b_q == '0);
        src1_neg  = ~op[0] & src1[WIDTH-1];
        a_ext     = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext     = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod      = a_ext * b_ext;
        // Partial remainder never exceeds WIDTH bits once the divisor is subtracted.
        rem_sh    = {rem, quo[WIDTH-1]};
        ge        = (rem_sh >= {1'b0, b_mag});
        rem_sub   = rem_sh[WIDTH-1:0] - b_mag;
        rem_nxt   = ge ? rem_sub : rem_sh[WIDTH-1:0];
        res_hi    = op_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo    = op_q[1] ? quo : prod[WIDTH-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && !cancel) state_nxt = op[1] ? S_DIV : S_MUL;
            S_MUL:  if (cancel) state_nxt = S_IDLE; else if (cnt == '0) state_nxt = S_DONE;
            S_DIV:  if (cancel) state_nxt = S_IDLE; else if (cnt == '0) state_nxt = S_FIX;
            S_FIX:  state_nxt = cancel ? S_IDLE : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE) && !cancel;
    assign arith_stall = ((state == S_IDLE) && start && !cancel)
                       || (state == S_MUL) || (state == S_DIV) || (state == S_FIX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            quo  <= '0;
            rem  <= '0;
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start && !cancel) begin
                    op_q <= op;
                    a_q  <= src1;
                    b_q  <= src2;
                    quo  <= src1_neg ? -src1 : src1;
                    rem  <= '0;
                    cnt  <= op[1] ? DIV_LOAD : MUL_LOAD;
                end
                S_MUL: cnt <= cnt - CW'(1);
                S_DIV: begin
                    quo <= {quo[WIDTH-2:0], ge};
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    // A zero divisor bypasses sign correction: all-ones quotient, raw dividend remainder.
                    if (div_zero) begin
                        quo <= '1;
                        rem <= a_q;
                    end else begin
                        quo <= (a_neg ^ b_neg) ? -quo : quo;
                        rem <= a_neg ? -rem : rem;
                    end
                end
                default: ;
            endcase
            if ((state == S_IDLE) || (state == S_DONE)) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
            if (done) begin
                if (!hi_we) hi <= res_hi;
                if (!lo_we) lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed testbench for exe_muldiv at default parameters, using hand-computed HI/LO results and latencies.
module tb_exe_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, cancel = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src1 = '0, src2 = '0, wdata = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done, arith_stall;
    logic         saw_done;
    int           n_checks = 0;
    int           n_errors = 0;

    exe_muldiv #(.WIDTH(W), .MUL_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
        .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .arith_stall(arith_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int lat;
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk);
        chk({tag, "_stall_start"}, 64'(arith_stall), 64'd1);
        tick;
        start = 1'b0;
        for (lat = 1; lat <= 100; lat++) begin
            @(negedge clk);
            if (done) break;
            chk({tag, "_stall_busy"}, 64'(arith_stall), 64'd1);
            tick;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_stall_done"}, 64'(arith_stall), 64'd0);
        tick;
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(arith_stall), 64'd0);
        #10 rst = 1'b0;
        tick;

        hi_we = 1'b1; wdata = 32'hDEADBEEF;
        tick;
        hi_we = 1'b0;
        chk("mthi", 64'(hi), 64'hDEADBEEF);
        lo_we = 1'b1; wdata = 32'hCAFEF00D;
        tick;
        lo_we = 1'b0;
        chk("mtlo", 64'(lo), 64'hCAFEF00D);

        start = 1'b1; cancel = 1'b1; op = 2'b00;
        @(negedge clk);
        chk("start_cancel_stall", 64'(arith_stall), 64'd0);
        tick;
        start = 1'b0; cancel = 1'b0;
        chk("start_cancel_idle", 64'(busy), 64'd0);

        run_op("mult_neg",   2'b00, 32'hFFFFFFFD, 32'd5,        3,  32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 3,  32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg2",  2'b00, 32'd7,        32'hFFFFFFFE, 3,  32'hFFFFFFFF, 32'hFFFFFFF2);
        run_op("div_neg",    2'b10, 32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 32'h00000000, 32'h80000000);
        run_op("divu_zero",  2'b11, 32'd100,      32'd0,        34, 32'h00000064, 32'hFFFFFFFF);
        run_op("div_zero",   2'b10, 32'hFFFFFFF9, 32'd0,        34, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_op("divu_basic", 2'b11, 32'd100,      32'd7,        34, 32'd2,        32'd14);

        // Cancel a divide mid-flight; HI/LO keep 2/14 and a multiply restarts immediately.
        op = 2'b10; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        saw_done = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            saw_done |= done;
            tick;
        end
        cancel = 1'b1;
        @(negedge clk);
        saw_done |= done;
        tick;
        cancel = 1'b0;
        chk("cancel_no_done", 64'(saw_done), 64'd0);
        chk("cancel_idle", 64'(busy), 64'd0);
        chk("cancel_hi", 64'(hi), 64'd2);
        chk("cancel_lo", 64'(lo), 64'd14);
        run_op("mult_after_cancel", 2'b00, 32'd6, 32'd7, 3, 32'd0, 32'd42);

        op = 2'b01; src1 = 32'd3; src2 = 32'd4; start = 1'b1;
        tick;
        start = 1'b0;
        hi_we = 1'b1; wdata = 32'h55;
        tick;
        hi_we = 1'b0;
        chk("mthi_in_mul_ignored", 64'(hi), 64'd0);
        tick;
        @(negedge clk);
        chk("mul_done_pulse", 64'(done), 64'd1);
        tick;
        chk("mul_commit_hi", 64'(hi), 64'd0);
        chk("mul_commit_lo", 64'(lo), 64'd12);

        op = 2'b01; src1 = 32'h10000000; src2 = 32'h20; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        lo_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        chk("collide_done", 64'(done), 64'd1);
        tick;
        lo_we = 1'b0;
        chk("collide_lo", 64'(lo), 64'h12345678);
        chk("collide_hi", 64'(hi), 64'd2);

        op = 2'b10; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        #1 rst = 1'b1;
        #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_stall", 64'(arith_stall), 64'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw_done |= done;
        end
        chk("midrst_no_done", 64'(saw_done), 64'd0);
        tick;
        run_op("multu_after_rst", 2'b01, 32'd3, 32'd4, 3, 32'd0, 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
